// File: rtl/bj_pkg.sv
// bj_pkg: shared types, result codes and card helpers for the blackjack
// round sequencer and its hand accumulators.
package bj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL_P1,
    ST_DEAL_D1,
    ST_DEAL_P2,
    ST_DEAL_D2,
    ST_PLAYER,
    ST_DEALER,
    ST_RESULT
  } state_e;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam logic [3:0] ACE      = 4'd1;
  localparam logic [4:0] BJ_SCORE = 5'd21;

  // Hard value of a rank: face cards count 10, ace counts 1.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    card_value = (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  // Ranks outside 1..13 are line noise from the card source.
  function automatic logic rank_ok(input logic [3:0] rank);
    rank_ok = (rank != 4'd0) && (rank <= 4'd13);
  endfunction

endpackage

// File: rtl/bj_hand_accum.sv
// bj_hand_accum: one blackjack hand. Keeps the hard sum, an ace flag and
// the card count, and presents the best score with ace-as-11 promotion.
module bj_hand_accum
  import bj_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [3:0] rank_i,
  output logic [4:0] score_o,
  output logic [2:0] count_o,
  output logic       soft_o,
  output logic       bust_o
);

  logic [4:0] hard_q, hard_d;
  logic       ace_q, ace_d;
  logic [2:0] count_q, count_d;
  logic [5:0] sum_w;

  assign sum_w = {1'b0, hard_q} + {2'b00, card_value(rank_i)};

  // Next hand contents; clear wins over add, hard sum saturates at 31.
  always_comb begin
    hard_d  = hard_q;
    ace_d   = ace_q;
    count_d = count_q;
    if (clear_i) begin
      hard_d  = '0;
      ace_d   = 1'b0;
      count_d = '0;
    end else if (add_i) begin
      hard_d  = (sum_w > 6'd31) ? 5'd31 : sum_w[4:0];
      ace_d   = ace_q | (rank_i == ACE);
      count_d = (count_q == 3'd7) ? count_q : count_q + 3'd1;
    end
  end

  // Hand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hard_q  <= '0;
      ace_q   <= 1'b0;
      count_q <= '0;
    end else begin
      hard_q  <= hard_d;
      ace_q   <= ace_d;
      count_q <= count_d;
    end
  end

  // An ace is promoted to 11 only while that keeps the hand at 21 or less.
  assign soft_o  = ace_q && (hard_q <= 5'd11);
  assign score_o = soft_o ? hard_q + 5'd10 : hard_q;
  assign count_o = count_q;
  assign bust_o  = score_o > BJ_SCORE;

endmodule

// File: rtl/bj_round_ctrl.sv
// bj_round_ctrl: blackjack round sequencer. Deals P,D,P,D from a
// request/valid card source, runs the player turn and dealer draw rule,
// and posts the round result.
// Build option: SOFT17_HIT_EN makes the dealer draw on a soft 17.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// DEAL_P1  | fetching player card 1
// DEAL_D1  | fetching dealer card 1
// DEAL_P2  | fetching player card 2
// DEAL_D2  | fetching dealer card 2, then natural check
// PLAYER   | player hit/stand, auto-advance on 21 / full hand / bust
// DEALER   | dealer draws below the stand score
// RESULT   | result and hands held until start
module bj_round_ctrl
  import bj_pkg::*;
#(
  parameter int DEALER_STAND = 17,
  parameter int MAX_HAND     = 5,
  parameter int WAIT_LIMIT   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  output logic       card_req,
  input  logic       card_valid,
  input  logic [3:0] card_in,
  output logic [4:0] player_score,
  output logic [4:0] dealer_score,
  output logic [2:0] player_count,
  output logic [2:0] dealer_count,
  output logic       busy,
  output logic [1:0] result
);

  localparam logic [4:0] STAND_SC  = 5'(DEALER_STAND);
  localparam logic [2:0] MAX_CNT   = 3'(MAX_HAND);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_LIMIT - 1);

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic       req_q, req_d;
  logic [3:0] wait_q, wait_d;
  logic [1:0] result_q, result_d;

  logic       clear_w, fetch_w, accept_w, add_p_w, add_d_w;
  logic       soft17_w, dealer_draw_w, dealer_nat_w;
  logic [4:0] p_score, d_score;
  logic [2:0] p_count, d_count;
  logic       p_soft, d_soft, p_bust, d_bust;

  assign accept_w = pending_q && card_valid && rank_ok(card_in);
  assign add_p_w  = accept_w && (state_q inside {ST_DEAL_P1, ST_DEAL_P2, ST_PLAYER});
  assign add_d_w  = accept_w && (state_q inside {ST_DEAL_D1, ST_DEAL_D2, ST_DEALER});

  bj_hand_accum u_player (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear_i (clear_w),
    .add_i   (add_p_w),
    .rank_i  (card_in),
    .score_o (p_score),
    .count_o (p_count),
    .soft_o  (p_soft),
    .bust_o  (p_bust)
  );

  bj_hand_accum u_dealer (
    .clk     (clk),
    .rst_n   (reset_n),
    .clear_i (clear_w),
    .add_i   (add_d_w),
    .rank_i  (card_in),
    .score_o (d_score),
    .count_o (d_count),
    .soft_o  (d_soft),
    .bust_o  (d_bust)
  );

`ifdef SOFT17_HIT_EN
  assign soft17_w = d_soft && (d_score == 5'd17);
`else
  assign soft17_w = 1'b0;
`endif

  assign dealer_draw_w = ((d_score < STAND_SC) || soft17_w) && (d_count < MAX_CNT);

  // Dealer's second card is still arriving in DEAL_D2, so a dealer natural
  // is predicted from the one held card plus the incoming rank.
  assign dealer_nat_w = ((d_score == 5'd10) && (card_in == ACE)) ||
                        (d_soft && (d_score == 5'd11) && (card_value(card_in) == 4'd10));

  // Next state, card fetch handshake and result.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    req_d     = 1'b0;
    wait_d    = wait_q;
    result_d  = result_q;
    clear_w   = 1'b0;
    fetch_w   = 1'b0;

    if (pending_q && !accept_w) begin
      if (wait_q == 4'd0) begin
        req_d  = 1'b1;
        wait_d = WAIT_LOAD;
      end else begin
        wait_d = wait_q - 4'd1;
      end
    end
    if (accept_w) pending_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (start) begin
          clear_w  = 1'b1;
          result_d = RES_NONE;
          state_d  = ST_DEAL_P1;
        end
      end
      ST_DEAL_P1: begin
        if (!pending_q) fetch_w = 1'b1;
        else if (accept_w) state_d = ST_DEAL_D1;
      end
      ST_DEAL_D1: begin
        if (!pending_q) fetch_w = 1'b1;
        else if (accept_w) state_d = ST_DEAL_P2;
      end
      ST_DEAL_P2: begin
        if (!pending_q) fetch_w = 1'b1;
        else if (accept_w) state_d = ST_DEAL_D2;
      end
      ST_DEAL_D2: begin
        if (!pending_q) begin
          fetch_w = 1'b1;
        end else if (accept_w) begin
          // A two-card 21 always holds an ace counted as 11.
          if (p_soft && (p_score == BJ_SCORE)) begin
            state_d  = ST_RESULT;
            result_d = dealer_nat_w ? RES_PUSH : RES_PLAYER;
          end else begin
            state_d = ST_PLAYER;
          end
        end
      end
      ST_PLAYER: begin
        if (!pending_q) begin
          if (p_bust) begin
            state_d  = ST_RESULT;
            result_d = RES_DEALER;
          end else if ((p_score == BJ_SCORE) || (p_count == MAX_CNT) || stand) begin
            state_d = ST_DEALER;
          end else if (hit) begin
            fetch_w = 1'b1;
          end
        end
      end
      ST_DEALER: begin
        if (!pending_q) begin
          if (d_bust) begin
            state_d  = ST_RESULT;
            result_d = RES_PLAYER;
          end else if (dealer_draw_w) begin
            fetch_w = 1'b1;
          end else begin
            state_d  = ST_RESULT;
            result_d = (p_score > d_score) ? RES_PLAYER :
                       (p_score < d_score) ? RES_DEALER : RES_PUSH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fetch_w) begin
      pending_d = 1'b1;
      req_d     = 1'b1;
      wait_d    = WAIT_LOAD;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
      wait_q    <= '0;
      result_q  <= RES_NONE;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      wait_q    <= wait_d;
      result_q  <= result_d;
    end
  end

  assign card_req     = req_q;
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_RESULT);
  assign result       = result_q;
  assign player_score = p_score;
  assign dealer_score = d_score;
  assign player_count = p_count;
  assign dealer_count = d_count;

endmodule
